// File: rtl/line_ram_ctrl_if.sv
// Line-RAM bus between the cache controller (master) and the line RAM (slave).
// Word i of a line travels in bits [i*WORD_W +: WORD_W] of the data buses.
interface line_ram_ctrl_if #(
   parameter int WORD_W         = 10,
   parameter int WORDS_PER_LINE = 2,
   parameter int ADDR_W         = 10
);
   logic                             mem_req;
   logic                             mem_we;
   logic [ADDR_W-1:0]                mem_addr;
   logic [WORD_W*WORDS_PER_LINE-1:0] mem_wdata;
   logic [WORDS_PER_LINE-1:0]        mem_wmask;
   logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata;
   logic                             mem_ready;
   logic                             mem_rvalid;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata, mem_ready, mem_rvalid
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata, mem_ready, mem_rvalid
   );
endinterface

// File: rtl/line_ram_ctrl.sv
// Line-organised word RAM: one line per mem_req/mem_ready handshake, with
// WAIT_CYCLES of latency, per-word write mask and a registered read line.
//
// state | meaning
// IDLE  | mem_ready high, accepting a request
// WAIT  | access in progress on latched fields; completes when cnt reaches 0
module line_ram_ctrl #(
   parameter int WORD_W         = 10,
   parameter int WORDS_PER_LINE = 2,
   parameter int ADDR_W         = 10,
   parameter int WAIT_CYCLES    = 1
) (
   input logic           clk,
   input logic           rst_n,
   line_ram_ctrl_if.slave bus
);
   localparam int OFF_W     = $clog2(WORDS_PER_LINE);
   localparam int LINE_W    = ADDR_W - OFF_W;
   localparam int NUM_LINES = 2 ** LINE_W;
   localparam int LINE_BITS = WORD_W * WORDS_PER_LINE;
   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("line_ram_ctrl: WAIT_CYCLES must be in 1..15");
   end
   if (WORDS_PER_LINE < 1 || WORDS_PER_LINE > 8 ||
       (2 ** OFF_W) != WORDS_PER_LINE) begin : g_bad_wpl
      $error("line_ram_ctrl: WORDS_PER_LINE must be a power of two in 1..8");
   end
   if (OFF_W > 0) begin : g_off
      logic unused_off;
      assign unused_off = ^bus.mem_addr[OFF_W-1:0];
   end

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                    state, state_nxt;
   logic [3:0]                cnt, cnt_nxt;
   logic                      accept, complete;
   logic [LINE_W-1:0]         line_q;
   logic                      we_q;
   logic [LINE_BITS-1:0]      wdata_q;
   logic [WORDS_PER_LINE-1:0] wmask_q;
   logic                      ready_q, rvalid_q;
   logic [LINE_BITS-1:0]      rdata_q, line_rd;

   logic [WORD_W-1:0] mem_array [NUM_LINES][WORDS_PER_LINE];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.mem_req && ready_q) begin
               accept    = 1'b1;
               cnt_nxt   = CNT_LOAD;
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         line_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         wmask_q  <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         rvalid_q <= complete && !we_q;
         if (accept) begin
            line_q  <= bus.mem_addr[ADDR_W-1:OFF_W];
            we_q    <= bus.mem_we;
            wdata_q <= bus.mem_wdata;
            wmask_q <= bus.mem_wmask;
            ready_q <= 1'b0;
         end
         if (complete) begin
            ready_q <= 1'b1;
            if (!we_q) rdata_q <= line_rd;
         end
      end
   end

   // Array has no reset; an access aborted by reset never reaches complete.
   always_ff @(posedge clk) begin
      if (complete && we_q) begin
         for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (wmask_q[i]) mem_array[line_q][i] <= wdata_q[i*WORD_W +: WORD_W];
         end
      end
   end

   always_comb begin
      line_rd = '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
         line_rd[i*WORD_W +: WORD_W] = mem_array[line_q][i];
      end
   end

   assign bus.mem_ready  = ready_q;
   assign bus.mem_rvalid = rvalid_q;
   assign bus.mem_rdata  = rdata_q;
endmodule

// File: tb/tb_line_ram_ctrl.sv
// Bench for line_ram_ctrl: a default instance (A) and a 4-word, 8-bit,
// 4-cycle instance (B), each checked every cycle against a line-level model.
module tb_line_ram_ctrl;
   localparam int WA = 1;
   localparam int WB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   line_ram_ctrl_if #(.WORD_W(10), .WORDS_PER_LINE(2), .ADDR_W(10)) ifa ();
   line_ram_ctrl_if #(.WORD_W(8),  .WORDS_PER_LINE(4), .ADDR_W(10)) ifb ();

   line_ram_ctrl #(.WORD_W(10), .WORDS_PER_LINE(2), .ADDR_W(10), .WAIT_CYCLES(WA))
      u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   line_ram_ctrl #(.WORD_W(8), .WORDS_PER_LINE(4), .ADDR_W(10), .WAIT_CYCLES(WB))
      u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] merge_a(input logic [19:0] old, input logic [19:0] wd,
                                           input logic [1:0] wm);
      logic [19:0] r;
      r = old;
      for (int i = 0; i < 2; i++) if (wm[i]) r[i*10 +: 10] = wd[i*10 +: 10];
      return r;
   endfunction

   function automatic logic [31:0] merge_b(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] wm);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (wm[i]) r[i*8 +: 8] = wd[i*8 +: 8];
      return r;
   endfunction

   // Model A: whole lines, access finishes WA edges after the accepting edge.
   logic [19:0] ma_mem [512];
   bit          ma_busy = 1'b0, ma_we = 1'b0;
   int          ma_t = 0, ma_due = 0, ma_line = 0;
   logic [19:0] ma_wd = '0;
   logic [1:0]  ma_wm = '0;
   logic        ea_ready = 1'b1, ea_rvalid = 1'b0;
   logic [19:0] ea_rdata = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma_busy   <= 1'b0;
         ea_ready  <= 1'b1;
         ea_rvalid <= 1'b0;
         ea_rdata  <= '0;
      end else begin
         ma_t      <= ma_t + 1;
         ea_rvalid <= 1'b0;
         if (ma_busy) begin
            if (ma_t == ma_due) begin
               ma_busy  <= 1'b0;
               ea_ready <= 1'b1;
               if (ma_we) ma_mem[ma_line] <= merge_a(ma_mem[ma_line], ma_wd, ma_wm);
               else begin
                  ea_rdata  <= ma_mem[ma_line];
                  ea_rvalid <= 1'b1;
               end
            end
         end else if (ifa.mem_req) begin
            ma_busy  <= 1'b1;
            ea_ready <= 1'b0;
            ma_due   <= ma_t + WA;
            ma_line  <= int'(ifa.mem_addr) / 2;
            ma_we    <= ifa.mem_we;
            ma_wd    <= ifa.mem_wdata;
            ma_wm    <= ifa.mem_wmask;
         end
      end
   end

   // Model B: same rules, 4 words of 8 bits, WB cycles.
   logic [31:0] mb_mem [256];
   bit          mb_busy = 1'b0, mb_we = 1'b0;
   int          mb_t = 0, mb_due = 0, mb_line = 0;
   logic [31:0] mb_wd = '0;
   logic [3:0]  mb_wm = '0;
   logic        eb_ready = 1'b1, eb_rvalid = 1'b0;
   logic [31:0] eb_rdata = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mb_busy   <= 1'b0;
         eb_ready  <= 1'b1;
         eb_rvalid <= 1'b0;
         eb_rdata  <= '0;
      end else begin
         mb_t      <= mb_t + 1;
         eb_rvalid <= 1'b0;
         if (mb_busy) begin
            if (mb_t == mb_due) begin
               mb_busy  <= 1'b0;
               eb_ready <= 1'b1;
               if (mb_we) mb_mem[mb_line] <= merge_b(mb_mem[mb_line], mb_wd, mb_wm);
               else begin
                  eb_rdata  <= mb_mem[mb_line];
                  eb_rvalid <= 1'b1;
               end
            end
         end else if (ifb.mem_req) begin
            mb_busy  <= 1'b1;
            eb_ready <= 1'b0;
            mb_due   <= mb_t + WB;
            mb_line  <= int'(ifb.mem_addr) / 4;
            mb_we    <= ifb.mem_we;
            mb_wd    <= ifb.mem_wdata;
            mb_wm    <= ifb.mem_wmask;
         end
      end
   end

   always @(negedge clk) begin
      check("a_ready",  {63'd0, ifa.mem_ready},  {63'd0, ea_ready});
      check("a_rvalid", {63'd0, ifa.mem_rvalid}, {63'd0, ea_rvalid});
      check("a_rdata",  {44'd0, ifa.mem_rdata},  {44'd0, ea_rdata});
      check("b_ready",  {63'd0, ifb.mem_ready},  {63'd0, eb_ready});
      check("b_rvalid", {63'd0, ifb.mem_rvalid}, {63'd0, eb_rvalid});
      check("b_rdata",  {32'd0, ifb.mem_rdata},  {32'd0, eb_rdata});
   end

   task automatic drive(input bit b, input bit req, input bit we, input int addr,
                        input logic [31:0] wd, input logic [3:0] wm);
      if (!b) begin
         ifa.mem_req = req; ifa.mem_we = we; ifa.mem_addr = addr[9:0];
         ifa.mem_wdata = wd[19:0]; ifa.mem_wmask = wm[1:0];
      end else begin
         ifb.mem_req = req; ifb.mem_we = we; ifb.mem_addr = addr[9:0];
         ifb.mem_wdata = wd; ifb.mem_wmask = wm;
      end
   endtask

   // One access; returns how many sampled cycles mem_ready was low.
   task automatic access(input bit b, input bit we, input int addr, input logic [31:0] wd,
                         input logic [3:0] wm, input bit pulse, output int low);
      bit rdy;
      @(negedge clk);
      drive(b, 1'b1, we, addr, wd, wm);
      @(negedge clk);
      low = 0;
      rdy = 1'b0;
      for (int k = 0; k < 40; k++) begin
         rdy = b ? ifb.mem_ready : ifa.mem_ready;
         if (rdy) break;
         low++;
         if (pulse && low == 2) drive(b, 1'b1, 1'b0, 0, 32'h0, 4'h0);
         else drive(b, 1'b0, we, addr, wd, wm);
         @(negedge clk);
      end
      check("ready_return", {63'd0, rdy}, 64'd1);
   endtask

   int low, n, t, last, rv_cnt;
   int          seq_addr [3] = '{'h10, 'h04, 'h10};
   logic [31:0] seq_data [3] = '{32'h44002211, 32'h0, 32'h44002211};

   initial begin
      for (int i = 0; i < 512; i++) ma_mem[i] = '0;
      for (int i = 0; i < 256; i++) mb_mem[i] = '0;
      drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      repeat (3) @(negedge clk);
      check("rst_ready_a", {63'd0, ifa.mem_ready}, 64'd1);
      check("rst_rdata_a", {44'd0, ifa.mem_rdata}, 64'd0);
      #2 rst_n = 1'b1;

      access(1'b0, 1'b0, 0, 32'h0, 4'h0, 1'b0, low);
      check("a_rd0_low", low, 1);
      check("a_rd0_rvalid", {63'd0, ifa.mem_rvalid}, 64'd1);
      check("a_rd0_data", {44'd0, ifa.mem_rdata}, 64'd0);

      access(1'b0, 1'b1, 7, {12'd0, 10'h2AA, 10'h155}, 4'b0011, 1'b0, low);
      check("a_wr_low", low, 1);
      check("a_wr_no_rvalid", {63'd0, ifa.mem_rvalid}, 64'd0);
      access(1'b0, 1'b0, 6, 32'h0, 4'h0, 1'b0, low);
      check("a_rd3_data", {44'd0, ifa.mem_rdata}, {44'd0, 10'h2AA, 10'h155});
      check("a_rd3_rvalid", {63'd0, ifa.mem_rvalid}, 64'd1);
      @(negedge clk);
      check("a_rvalid_one_cycle", {63'd0, ifa.mem_rvalid}, 64'd0);

      access(1'b0, 1'b1, 6, {12'd0, 10'h3FF, 10'h000}, 4'b0001, 1'b0, low);
      access(1'b0, 1'b0, 7, 32'h0, 4'h0, 1'b0, low);
      check("a_masked_data", {44'd0, ifa.mem_rdata}, {44'd0, 10'h2AA, 10'h000});

      access(1'b0, 1'b1, 6, {12'd0, 10'h111, 10'h222}, 4'b0000, 1'b0, low);
      check("a_nomask_low", low, 1);
      access(1'b0, 1'b0, 6, 32'h0, 4'h0, 1'b0, low);
      check("a_nomask_data", {44'd0, ifa.mem_rdata}, {44'd0, 10'h2AA, 10'h000});

      access(1'b0, 1'b1, 1023, {12'd0, 10'h0AB, 10'h0CD}, 4'b0011, 1'b0, low);
      access(1'b0, 1'b0, 1022, 32'h0, 4'h0, 1'b0, low);
      check("a_top_line", {44'd0, ifa.mem_rdata}, {44'd0, 10'h0AB, 10'h0CD});

      access(1'b1, 1'b1, 'h13, 32'h44332211, 4'b1011, 1'b0, low);
      check("b_wr_low", low, 4);
      access(1'b1, 1'b0, 'h10, 32'h0, 4'h0, 1'b1, low);
      check("b_rd_low", low, 4);
      check("b_rd_data", {32'd0, ifb.mem_rdata}, 64'h44002211);
      check("b_rd_rvalid", {63'd0, ifb.mem_rvalid}, 64'd1);
      rv_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ifb.mem_rvalid) rv_cnt++;
      end
      check("b_wait_req_ignored", rv_cnt, 0);

      @(negedge clk);
      drive(1'b1, 1'b1, 1'b0, seq_addr[0], 32'h0, 4'h0);
      n = 0; t = 0; last = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         t++;
         if (ifb.mem_rvalid) begin
            check("b_seq_data", {32'd0, ifb.mem_rdata}, {32'd0, seq_data[n]});
            if (n > 0) check("b_seq_spacing", t - last, WB + 1);
            last = t;
            n++;
            if (n == 3) begin
               drive(1'b1, 1'b0, 1'b0, 0, 32'h0, 4'h0);
               break;
            end
            drive(1'b1, 1'b1, 1'b0, seq_addr[n], 32'h0, 4'h0);
         end
      end
      check("b_seq_count", n, 3);
      repeat (8) @(negedge clk);
      check("b_seq_no_extra", {63'd0, ifb.mem_ready}, 64'd1);

      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 6, {12'd0, 10'h155, 10'h2AA}, 4'b0011);
      @(negedge clk);
      check("a_abort_busy", {63'd0, ifa.mem_ready}, 64'd0);
      drive(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0);
      #2 rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("a_abort_rvalid", {63'd0, ifa.mem_rvalid}, 64'd0);
         check("a_abort_ready", {63'd0, ifa.mem_ready}, 64'd1);
      end
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("a_after_rst_ready", {63'd0, ifa.mem_ready}, 64'd1);
      access(1'b0, 1'b0, 7, 32'h0, 4'h0, 1'b0, low);
      check("a_abort_data", {44'd0, ifa.mem_rdata}, {44'd0, 10'h2AA, 10'h000});

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end
endmodule
